// File: rtl/tele_pkg.sv
// Shared types, status strings, ASCII class bounds and arithmetic helpers
// for the two-party call controller.
package tele_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRinging,
    StRejected,
    StCaller,
    StCallee,
    StCost
  } tele_state_e;

  localparam logic [63:0] StrIdle     = "IDLE    ";
  localparam logic [63:0] StrRinging  = "RINGING ";
  localparam logic [63:0] StrRejected = "REJECTED";
  localparam logic [63:0] StrCaller   = "CALLER  ";
  localparam logic [63:0] StrCallee   = "CALLEE  ";
  localparam logic [63:0] StrCost     = "COST    ";

  localparam logic [7:0] AsciiDigitLo = 8'h30;
  localparam logic [7:0] AsciiDigitHi = 8'h39;
  localparam logic [7:0] AsciiPrintLo = 8'h20;
  localparam logic [7:0] AsciiPrintHi = 8'h7F;

  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
    if (nib < 4'd10) return 8'h30 + {4'h0, nib};
    return 8'h37 + {4'h0, nib};
  endfunction

  // Saturating add clamped to an all-ones value of 'width' bits (width <= 64).
  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                          input int unsigned width);
    logic [64:0] sum;
    logic [63:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    if (sum > {1'b0, lim}) return lim;
    return sum[63:0];
  endfunction

endpackage

// File: rtl/tele_call_ctrl_p_if.sv
// Phone-side signal bundle of the call controller.
interface tele_call_ctrl_p_if #(
  parameter int unsigned MSG_CHARS = 8,
  parameter int unsigned COST_W    = 32
);
  logic                   start_call;
  logic                   answer_call;
  logic                   end_call_caller;
  logic                   end_call_callee;
  logic                   send_char_caller;
  logic                   send_char_callee;
  logic [7:0]             char_sent;
  logic [63:0]            status_msg;
  logic [8*MSG_CHARS-1:0] sent_msg;
  logic [COST_W-1:0]      cost;
  logic [COST_W-1:0]      total_cost;
  logic [15:0]            char_count;
  logic                   call_active;

  modport master (
    output start_call, answer_call, end_call_caller, end_call_callee,
           send_char_caller, send_char_callee, char_sent,
    input  status_msg, sent_msg, cost, total_cost, char_count, call_active
  );

  modport slave (
    input  start_call, answer_call, end_call_caller, end_call_callee,
           send_char_caller, send_char_callee, char_sent,
    output status_msg, sent_msg, cost, total_cost, char_count, call_active
  );
endinterface

// File: rtl/tele_cost_fmt.sv
// Combinational cost -> uppercase hex ASCII, least significant nibble in byte 0.
module tele_cost_fmt
  import tele_pkg::*;
#(
  parameter int unsigned COST_W    = 32,
  parameter int unsigned MSG_CHARS = 8
) (
  input  logic [COST_W-1:0]      i_cost,
  output logic [8*MSG_CHARS-1:0] o_hex
);

  for (genvar gi = 0; gi < MSG_CHARS; gi++) begin : g_byte
    if (gi < COST_W / 4) begin : g_nib
      assign o_hex[8*gi +: 8] = nibble_to_ascii(i_cost[4*gi +: 4]);
    end else begin : g_pad
      assign o_hex[8*gi +: 8] = 8'h30;
    end
  end

endmodule

// File: rtl/tele_call_ctrl_p.sv
// Two-party call controller: ring/answer/talk/cost sequencing with per-character
// charging, a shift buffer of sent characters and a cumulative bill.
module tele_call_ctrl_p
  import tele_pkg::*;
#(
  parameter int unsigned MSG_CHARS     = 8,
  parameter int unsigned COST_W        = 32,
  parameter int unsigned RING_CYCLES   = 10,
  parameter int unsigned REJECT_CYCLES = 10,
  parameter int unsigned COST_CYCLES   = 5,
  parameter int unsigned DIGIT_COST    = 1,
  parameter int unsigned CHAR_COST     = 2,
  parameter logic [7:0]  TURN_CHAR     = 8'h7F,
  parameter int unsigned IDLE_TIMEOUT  = 0
) (
  input logic               clk,
  input logic               rst_n,
  tele_call_ctrl_p_if.slave bus
);

  tele_state_e            r_state, w_state_d;
  logic [31:0]            r_timer, w_timer_d;
  logic [31:0]            r_idle_cnt, w_idle_cnt_d;
  logic [COST_W-1:0]      r_cost, w_cost_d;
  logic [COST_W-1:0]      r_total, w_total_d;
  logic [15:0]            r_count, w_count_d;
  logic [8*MSG_CHARS-1:0] r_sent, w_sent_d, w_cost_hex;
  logic                   w_talk, w_valid, w_charged, w_is_digit, w_turn, w_idle_expire;

  always_comb begin
    w_talk     = (r_state == StCaller) || (r_state == StCallee);
    w_valid    = ((r_state == StCaller) && bus.send_char_caller) ||
                 ((r_state == StCallee) && bus.send_char_callee);
    w_is_digit = (bus.char_sent >= AsciiDigitLo) && (bus.char_sent <= AsciiDigitHi);
    w_charged  = w_valid && (bus.char_sent >= AsciiPrintLo) && (bus.char_sent <= AsciiPrintHi);
    w_turn     = w_valid && (bus.char_sent == TURN_CHAR);
    w_idle_expire = (IDLE_TIMEOUT != 0) && w_talk && !w_valid &&
                    (r_idle_cnt == 32'(IDLE_TIMEOUT - 1));
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:     if (bus.start_call) w_state_d = StRinging;
      StRinging: begin
        if (bus.end_call_caller || (r_timer == 32'(RING_CYCLES - 1))) w_state_d = StIdle;
        else if (bus.end_call_callee)                                  w_state_d = StRejected;
        else if (bus.answer_call)                                      w_state_d = StCaller;
      end
      StRejected: if (r_timer == 32'(REJECT_CYCLES - 1)) w_state_d = StIdle;
      StCaller: begin
        if (bus.end_call_caller || bus.end_call_callee) w_state_d = StCost;
        else if (w_turn)                                w_state_d = StCallee;
        else if (w_idle_expire)                         w_state_d = StCost;
      end
      StCallee: begin
        if (bus.end_call_caller || bus.end_call_callee) w_state_d = StCost;
        else if (w_turn)                                w_state_d = StCaller;
        else if (w_idle_expire)                         w_state_d = StCost;
      end
      StCost:     if (r_timer == 32'(COST_CYCLES - 1)) w_state_d = StIdle;
      default:    w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_timer_d = r_timer;
    if (w_state_d != r_state) begin
      w_timer_d = '0;
    end else if (r_state inside {StRinging, StRejected, StCost}) begin
      w_timer_d = r_timer + 32'd1;
    end

    // Any valid send or state change (incl. turn passing) restarts inactivity.
    w_idle_cnt_d = '0;
    if (w_talk && (w_state_d == r_state) && !w_valid) w_idle_cnt_d = r_idle_cnt + 32'd1;

    w_cost_d  = r_cost;
    w_count_d = r_count;
    w_total_d = r_total;
    if ((r_state == StIdle) && bus.start_call) begin
      w_cost_d  = '0;
      w_count_d = '0;
    end else if (w_charged) begin
      w_cost_d  = COST_W'(sat_add(64'(r_cost), w_is_digit ? 64'(DIGIT_COST) : 64'(CHAR_COST),
                                  COST_W));
      w_count_d = (r_count == 16'hFFFF) ? r_count : r_count + 16'd1;
    end
    if ((r_state == StCost) && (w_state_d == StIdle)) begin
      w_total_d = COST_W'(sat_add(64'(r_total), 64'(r_cost), COST_W));
    end
  end

  tele_cost_fmt #(
    .COST_W    (COST_W),
    .MSG_CHARS (MSG_CHARS)
  ) u_cost_fmt (
    .i_cost (w_cost_d),
    .o_hex  (w_cost_hex)
  );

  // Hex display is loaded on the entry edge too, so it is visible for all COST cycles.
  always_comb begin
    w_sent_d = r_sent;
    if ((r_state == StIdle) && bus.start_call) begin
      w_sent_d = '0;
    end else if (w_charged) begin
      w_sent_d = (r_sent << 8) | (8*MSG_CHARS)'(bus.char_sent);
    end
    if (w_state_d == StCost) w_sent_d = w_cost_hex;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_timer    <= '0;
      r_idle_cnt <= '0;
      r_cost     <= '0;
      r_total    <= '0;
      r_count    <= '0;
      r_sent     <= '0;
    end else begin
      r_state    <= w_state_d;
      r_timer    <= w_timer_d;
      r_idle_cnt <= w_idle_cnt_d;
      r_cost     <= w_cost_d;
      r_total    <= w_total_d;
      r_count    <= w_count_d;
      r_sent     <= w_sent_d;
    end
  end

  always_comb begin
    bus.status_msg = StrIdle;
    unique case (r_state)
      StIdle:     bus.status_msg = StrIdle;
      StRinging:  bus.status_msg = StrRinging;
      StRejected: bus.status_msg = StrRejected;
      StCaller:   bus.status_msg = StrCaller;
      StCallee:   bus.status_msg = StrCallee;
      StCost:     bus.status_msg = StrCost;
      default:    bus.status_msg = StrIdle;
    endcase
  end

  assign bus.call_active = w_talk;
  assign bus.sent_msg    = r_sent;
  assign bus.cost        = r_cost;
  assign bus.total_cost  = r_total;
  assign bus.char_count  = r_count;

endmodule

// File: tb/tb_tele_call_ctrl_p.sv
// Bench for tele_call_ctrl_p: three parameterisations share one stimulus stream;
// each scenario checks the instance whose parameters it targets.
module tb_tele_call_ctrl_p;

  localparam logic [63:0] S_IDLE = "IDLE    ";
  localparam logic [63:0] S_RING = "RINGING ";
  localparam logic [63:0] S_REJ  = "REJECTED";
  localparam logic [63:0] S_CLR  = "CALLER  ";
  localparam logic [63:0] S_CLE  = "CALLEE  ";
  localparam logic [63:0] S_COST = "COST    ";

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start_call, answer_call, end_caller, end_callee, send_caller, send_callee;
  logic [7:0] ch;
  int         n_tests = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  tele_call_ctrl_p_if #(.MSG_CHARS(8), .COST_W(32)) if_def ();
  tele_call_ctrl_p_if #(.MSG_CHARS(2), .COST_W(8))  if_sat ();
  tele_call_ctrl_p_if #(.MSG_CHARS(8), .COST_W(32)) if_ito ();

  assign if_def.start_call = start_call;       assign if_sat.start_call = start_call;
  assign if_def.answer_call = answer_call;     assign if_sat.answer_call = answer_call;
  assign if_def.end_call_caller = end_caller;  assign if_sat.end_call_caller = end_caller;
  assign if_def.end_call_callee = end_callee;  assign if_sat.end_call_callee = end_callee;
  assign if_def.send_char_caller = send_caller; assign if_sat.send_char_caller = send_caller;
  assign if_def.send_char_callee = send_callee; assign if_sat.send_char_callee = send_callee;
  assign if_def.char_sent = ch;                assign if_sat.char_sent = ch;
  assign if_ito.start_call = start_call;
  assign if_ito.answer_call = answer_call;
  assign if_ito.end_call_caller = end_caller;
  assign if_ito.end_call_callee = end_callee;
  assign if_ito.send_char_caller = send_caller;
  assign if_ito.send_char_callee = send_callee;
  assign if_ito.char_sent = ch;

  tele_call_ctrl_p u_def (.clk(clk), .rst_n(rst_n), .bus(if_def));
  tele_call_ctrl_p #(.MSG_CHARS(2), .COST_W(8)) u_sat (.clk(clk), .rst_n(rst_n), .bus(if_sat));
  tele_call_ctrl_p #(.IDLE_TIMEOUT(4)) u_ito (.clk(clk), .rst_n(rst_n), .bus(if_ito));

  typedef struct {
    logic        s, a, ec, ee, sc, se;
    logic [7:0]  c;
    logic [63:0] status;
    logic [31:0] cost, total;
    logic [15:0] cnt;
    logic        active;
    logic [63:0] sent;
  } vec_t;

  vec_t        vecs[$];
  logic [7:0]  mq[$];   // model of sent buffer, newest first

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic step(input logic s, input logic a, input logic ec, input logic ee,
                      input logic sc, input logic se, input logic [7:0] c);
    start_call = s; answer_call = a; end_caller = ec; end_callee = ee;
    send_caller = sc; send_callee = se; ch = c;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic do_reset();
    start_call = 0; answer_call = 0; end_caller = 0; end_callee = 0;
    send_caller = 0; send_callee = 0; ch = 8'h00;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic add_vec(input logic s, input logic a, input logic ec, input logic ee,
                         input logic sc, input logic se, input logic [7:0] c,
                         input logic [63:0] st, input logic [31:0] co, input logic [31:0] tot,
                         input logic [15:0] cn, input logic act, input logic [63:0] sm);
    vec_t v;
    v.s = s; v.a = a; v.ec = ec; v.ee = ee; v.sc = sc; v.se = se; v.c = c;
    v.status = st; v.cost = co; v.total = tot; v.cnt = cn; v.active = act; v.sent = sm;
    vecs.push_back(v);
  endtask

  function automatic logic [63:0] hex_of(input logic [63:0] v, input int n);
    string       digs;
    logic [63:0] b;
    logic [3:0]  d;
    digs = "0123456789ABCDEF";
    b = '0;
    for (int i = 0; i < n; i++) begin
      d = v[4*i +: 4];
      b[8*i +: 8] = digs[int'(d)];
    end
    return b;
  endfunction

  function automatic logic [63:0] model_buf();
    logic [63:0] b;
    b = '0;
    for (int i = 0; i < mq.size(); i++) b[8*i +: 8] = mq[i];
    return b;
  endfunction

  function automatic logic [7:0] pick_char();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r < 3) return 8'(8'h30 + $urandom_range(0, 9));
    if (r < 6) return 8'($urandom_range(8'h20, 8'h7E));
    if (r == 6) return 8'($urandom_range(0, 8'h1F));
    if (r == 7) return 8'($urandom_range(8'h80, 8'hFF));
    return 8'h7F;
  endfunction

  initial begin
    logic        sc_r, se_r, valid, m_callee;
    logic [7:0]  c;
    int unsigned m_cost, m_cnt;

    // Reset state
    do_reset();
    chk("rst.status", if_def.status_msg, S_IDLE);
    chk("rst.cost", 64'(if_def.cost), 64'd0);
    chk("rst.total", 64'(if_def.total_cost), 64'd0);
    chk("rst.count", 64'(if_def.char_count), 64'd0);
    chk("rst.sent", if_def.sent_msg, 64'd0);
    chk("rst.active", 64'(if_def.call_active), 64'd0);

    // Unanswered call: RINGING for exactly RING_CYCLES cycles
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("ring.0", if_def.status_msg, S_RING);
    for (int i = 1; i < 10; i++) begin
      idle_step();
      chk($sformatf("ring.%0d", i), if_def.status_msg, S_RING);
    end
    idle_step();
    chk("ring.end", if_def.status_msg, S_IDLE);
    chk("ring.cost", 64'(if_def.cost), 64'd0);
    chk("ring.total", 64'(if_def.total_cost), 64'd0);

    // Answered call table
    add_vec(1,0,0,0,0,0,8'h00, S_RING, 0, 0, 0, 0, 64'h0);
    add_vec(0,1,0,0,0,0,8'h00, S_CLR,  0, 0, 0, 1, 64'h0);
    add_vec(0,0,0,0,1,0,8'h34, S_CLR,  1, 0, 1, 1, 64'h34);
    add_vec(0,0,0,0,1,0,8'h41, S_CLR,  3, 0, 2, 1, 64'h3441);
    add_vec(0,0,0,0,1,0,8'h7F, S_CLE,  5, 0, 3, 1, 64'h34417F);
    add_vec(0,0,0,0,0,1,8'h01, S_CLE,  5, 0, 3, 1, 64'h34417F);
    add_vec(0,0,0,0,0,1,8'h39, S_CLE,  6, 0, 4, 1, 64'h34417F39);
    add_vec(0,0,0,0,1,0,8'h35, S_CLE,  6, 0, 4, 1, 64'h34417F39);
    add_vec(0,0,0,1,0,0,8'h00, S_COST, 6, 0, 4, 0, 64'h3030303030303036);
    add_vec(0,0,0,0,0,0,8'h00, S_COST, 6, 0, 4, 0, 64'h3030303030303036);
    add_vec(1,1,1,0,0,0,8'h00, S_COST, 6, 0, 4, 0, 64'h3030303030303036);
    add_vec(0,0,0,1,0,0,8'h00, S_COST, 6, 0, 4, 0, 64'h3030303030303036);
    add_vec(0,0,0,0,0,0,8'h00, S_COST, 6, 0, 4, 0, 64'h3030303030303036);
    add_vec(0,0,0,0,0,0,8'h00, S_IDLE, 6, 6, 4, 0, 64'h3030303030303036);
    foreach (vecs[i]) begin
      step(vecs[i].s, vecs[i].a, vecs[i].ec, vecs[i].ee, vecs[i].sc, vecs[i].se, vecs[i].c);
      chk($sformatf("vec%0d.status", i), if_def.status_msg, vecs[i].status);
      chk($sformatf("vec%0d.cost", i), 64'(if_def.cost), 64'(vecs[i].cost));
      chk($sformatf("vec%0d.total", i), 64'(if_def.total_cost), 64'(vecs[i].total));
      chk($sformatf("vec%0d.count", i), 64'(if_def.char_count), 64'(vecs[i].cnt));
      chk($sformatf("vec%0d.active", i), 64'(if_def.call_active), 64'(vecs[i].active));
      chk($sformatf("vec%0d.sent", i), if_def.sent_msg, vecs[i].sent);
    end

    // Rejection: answer_call ignored while REJECTED, total kept
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    chk("rej.0", if_def.status_msg, S_REJ);
    for (int i = 1; i < 10; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      chk($sformatf("rej.%0d", i), if_def.status_msg, S_REJ);
    end
    idle_step();
    chk("rej.end", if_def.status_msg, S_IDLE);
    chk("rej.total", 64'(if_def.total_cost), 64'd6);

    // Saturation on the 8-bit cost instance
    do_reset();
    for (int call = 0; call < 2; call++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      for (int i = 0; i < 130; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h41);
      chk($sformatf("sat%0d.cost", call), 64'(if_sat.cost), 64'hFF);
      chk($sformatf("sat%0d.count", call), 64'(if_sat.char_count), 64'd130);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      chk($sformatf("sat%0d.hex", call), 64'(if_sat.sent_msg), 64'h4646);
      repeat (5) idle_step();
      chk($sformatf("sat%0d.status", call), if_sat.status_msg, S_IDLE);
      chk($sformatf("sat%0d.total", call), 64'(if_sat.total_cost), 64'hFF);
    end

    // Inactivity hang-up, no sends
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 1; i <= 3; i++) begin
      idle_step();
      chk($sformatf("ito.a%0d", i), if_ito.status_msg, S_CLR);
    end
    idle_step();
    chk("ito.a4", if_ito.status_msg, S_COST);
    // Inactivity hang-up, send in talk cycle 3 restarts the count
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    idle_step();
    idle_step();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h41);
    for (int i = 4; i <= 6; i++) begin
      idle_step();
      chk($sformatf("ito.b%0d", i), if_ito.status_msg, S_CLR);
    end
    idle_step();
    chk("ito.b7", if_ito.status_msg, S_COST);
    chk("ito.disabled", if_def.status_msg, S_CLR);

    // Asynchronous reset mid-CALLEE, then a fresh call
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h34);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h7F);
    chk("mid.pre", if_def.status_msg, S_CLE);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid.status", if_def.status_msg, S_IDLE);
    chk("mid.cost", 64'(if_def.cost), 64'd0);
    chk("mid.sent", if_def.sent_msg, 64'd0);
    chk("mid.count", 64'(if_def.char_count), 64'd0);
    chk("mid.active", 64'(if_def.call_active), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h34);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h41);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    repeat (5) idle_step();
    chk("new.total3", 64'(if_def.total_cost), 64'd3);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("new.status", if_def.status_msg, S_RING);
    chk("new.cost", 64'(if_def.cost), 64'd0);
    chk("new.sent", if_def.sent_msg, 64'd0);
    chk("new.count", 64'(if_def.char_count), 64'd0);
    chk("new.total", 64'(if_def.total_cost), 64'd3);

    // Randomised talk against a call-level model
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    m_cost = 0; m_cnt = 0; m_callee = 1'b0; mq.delete();
    for (int k = 0; k < 300; k++) begin
      sc_r = 1'($urandom_range(0, 1));
      se_r = 1'($urandom_range(0, 1));
      c = pick_char();
      step(1'b0, 1'b0, 1'b0, 1'b0, sc_r, se_r, c);
      valid = m_callee ? se_r : sc_r;
      if (valid && c >= 8'h20 && c <= 8'h7F) begin
        m_cost += (c >= 8'h30 && c <= 8'h39) ? 1 : 2;
        m_cnt++;
        mq.push_front(c);
        if (mq.size() > 8) void'(mq.pop_back());
      end
      if (valid && c == 8'h7F) m_callee = !m_callee;
      chk($sformatf("rnd%0d.status", k), if_def.status_msg, m_callee ? S_CLE : S_CLR);
      chk($sformatf("rnd%0d.cost", k), 64'(if_def.cost), 64'(m_cost));
      chk($sformatf("rnd%0d.count", k), 64'(if_def.char_count), 64'(m_cnt));
      chk($sformatf("rnd%0d.sent", k), if_def.sent_msg, model_buf());
    end
    // Send and hang-up in the same cycle: the digit is still charged
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h35);
    m_cost += 1;
    m_cnt++;
    chk("rnd.end.status", if_def.status_msg, S_COST);
    chk("rnd.end.cost", 64'(if_def.cost), 64'(m_cost));
    chk("rnd.end.count", 64'(if_def.char_count), 64'(m_cnt));
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rnd.hex%0d", i), if_def.sent_msg, hex_of(64'(m_cost), 8));
      idle_step();
    end
    chk("rnd.hex4", if_def.sent_msg, hex_of(64'(m_cost), 8));
    idle_step();
    chk("rnd.idle", if_def.status_msg, S_IDLE);
    chk("rnd.total", 64'(if_def.total_cost), 64'(m_cost));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
